// File: rtl/la_prog_loader.sv
// Program loader driven from logic-analyzer pins: decodes toggle-strobed commands
// into single-word memory writes/reads and owns the core's reset.
module la_prog_loader #(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic [31:0]       la_cmd_data_i,
  input  logic [ADDR_W-1:0] la_cmd_addr_i,
  input  logic [1:0]        la_cmd_op_i,
  input  logic              la_cmd_tgl_i,
  output logic [31:0]       la_rsp_data_o,
  output logic              la_rsp_tgl_o,
  output logic              la_rsp_err_o,
  output logic              la_busy_o,
  output logic [15:0]       la_wcount_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              core_rst_n_o
);

  // Memory handshake: mem_req_o stays high with stable addr/data/we until the
  // edge that samples mem_ack_i high (or the timeout); ack outside BUSY is ignored.

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  localparam logic [1:0]  OP_WRITE = 2'b00;
  localparam logic [1:0]  OP_READ  = 2'b01;
  localparam logic [1:0]  OP_RUN   = 2'b10;
  localparam logic [1:0]  OP_HOLD  = 2'b11;
  localparam logic [7:0]  TMO      = 8'(TIMEOUT);
  localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;

  state_t     state;
  logic       tgl_seen;
  logic [7:0] tmo_cnt;
  logic       pending;

  assign pending = (la_cmd_tgl_i != tgl_seen);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state         <= S_INIT;
      tgl_seen      <= 1'b0;
      tmo_cnt       <= 8'd0;
      la_rsp_data_o <= 32'd0;
      la_rsp_tgl_o  <= 1'b0;
      la_rsp_err_o  <= 1'b0;
      la_busy_o     <= 1'b0;
      la_wcount_o   <= 16'd0;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= 32'd0;
      core_rst_n_o  <= 1'b0;
    end else begin
      case (state)
        // Absorb whatever strobe level is present at reset release.
        S_INIT: begin
          tgl_seen <= la_cmd_tgl_i;
          state    <= S_IDLE;
        end

        S_IDLE: begin
          if (pending) begin
            tgl_seen <= la_cmd_tgl_i;
            case (la_cmd_op_i)
              OP_RUN: begin
                core_rst_n_o <= 1'b1;
                la_rsp_err_o <= 1'b0;
                la_rsp_tgl_o <= ~la_rsp_tgl_o;
              end
              OP_HOLD: begin
                core_rst_n_o <= 1'b0;
                la_wcount_o  <= 16'd0;
                la_rsp_err_o <= 1'b0;
                la_rsp_tgl_o <= ~la_rsp_tgl_o;
              end
              default: begin
                // Memory access is only allowed while the core is held.
                if (core_rst_n_o) begin
                  la_rsp_err_o <= 1'b1;
                  la_rsp_tgl_o <= ~la_rsp_tgl_o;
                end else begin
                  state       <= S_BUSY;
                  mem_req_o   <= 1'b1;
                  la_busy_o   <= 1'b1;
                  mem_we_o    <= (la_cmd_op_i == OP_WRITE);
                  mem_addr_o  <= la_cmd_addr_i;
                  mem_wdata_o <= la_cmd_data_i;
                  tmo_cnt     <= 8'd0;
                end
              end
            endcase
          end
        end

        S_BUSY: begin
          if (mem_ack_i) begin
            state        <= S_IDLE;
            mem_req_o    <= 1'b0;
            la_busy_o    <= 1'b0;
            la_rsp_err_o <= 1'b0;
            la_rsp_tgl_o <= ~la_rsp_tgl_o;
            if (mem_we_o) begin
              if (la_wcount_o != 16'hFFFF) la_wcount_o <= la_wcount_o + 16'd1;
            end else begin
              la_rsp_data_o <= mem_rdata_i;
            end
          end else if (tmo_cnt == TMO) begin
            state         <= S_IDLE;
            mem_req_o     <= 1'b0;
            la_busy_o     <= 1'b0;
            la_rsp_err_o  <= 1'b1;
            la_rsp_data_o <= TMO_DATA;
            la_rsp_tgl_o  <= ~la_rsp_tgl_o;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        default: state <= S_INIT;
      endcase
    end
  end

  // The op encodings for READ is implied by mem_we_o == 0 once BUSY.
  logic unused_op_read;
  assign unused_op_read = (OP_READ == 2'b01);

endmodule

// File: tb/tb_la_prog_loader.sv
// Directed bench for la_prog_loader: response scoreboard plus a behavioural
// memory with programmable ack delay (0 = never acknowledge).
module tb_la_prog_loader;

  localparam int ADDR_W = 14;
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_HOLD  = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic [31:0]       cmd_data = 32'd0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [1:0]        cmd_op = 2'b00;
  logic              cmd_tgl = 1'b0;
  logic [31:0]       rsp_data;
  logic              rsp_tgl;
  logic              rsp_err;
  logic              busy;
  logic [15:0]       wcount;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = 32'd0;
  logic              mem_ack = 1'b0;
  logic              core_rst_n;

  la_prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(255)) dut (
    .wb_clk_i      (clk),
    .wb_rst_n_i    (rst_n),
    .la_cmd_data_i (cmd_data),
    .la_cmd_addr_i (cmd_addr),
    .la_cmd_op_i   (cmd_op),
    .la_cmd_tgl_i  (cmd_tgl),
    .la_rsp_data_o (rsp_data),
    .la_rsp_tgl_o  (rsp_tgl),
    .la_rsp_err_o  (rsp_err),
    .la_busy_o     (busy),
    .la_wcount_o   (wcount),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata),
    .mem_ack_i     (mem_ack),
    .core_rst_n_o  (core_rst_n)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model, evaluated mid-cycle so ack/rdata are stable at the next edge.
  int          ack_delay = 1;
  logic        ack_stray = 1'b0;
  int          req_cyc = 0;
  int          req_total = 0;
  int          last_len = 0;
  logic        cur_we = 1'b0;
  logic        last_we = 1'b0;
  logic [31:0] mem [256];

  always @(negedge clk) begin
    if (mem_req) begin
      req_cyc   <= req_cyc + 1;
      req_total <= req_total + 1;
      if (req_cyc == 0) cur_we <= mem_we;
      mem_ack   <= ack_stray || (ack_delay != 0 && req_cyc + 1 == ack_delay);
      mem_rdata <= mem[mem_addr[7:0]];
      if (mem_we && ack_delay != 0 && req_cyc + 1 == ack_delay)
        mem[mem_addr[7:0]] <= mem_wdata;
    end else begin
      if (req_cyc != 0) begin
        last_len <= req_cyc;
        last_we  <= cur_we;
      end
      req_cyc   <= 0;
      mem_ack   <= ack_stray;
      mem_rdata <= 32'd0;
    end
  end

  // Response monitor: logs {err, wcount, data} and cycle at every strobe flip.
  logic        prev_tgl = 1'b0;
  int          obs_cnt = 0;
  logic [48:0] obs_log [64];
  int          obs_cyc [64];

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_tgl <= rsp_tgl;
    end else if (rsp_tgl !== prev_tgl) begin
      prev_tgl            <= rsp_tgl;
      obs_log[obs_cnt%64] <= {rsp_err, wcount, rsp_data};
      obs_cyc[obs_cnt%64] <= cyc;
      obs_cnt             <= obs_cnt + 1;
    end
  end

  int          total = 0;
  int          bad = 0;
  logic [48:0] exp_q[$];
  int          rd_idx = 0;
  int          issue_cyc = 0;
  int          last_rsp_cyc = 0;
  logic [15:0] m_wc = 16'd0;
  logic [31:0] m_data = 32'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_tgl   = ~cmd_tgl;
    issue_cyc = cyc;
  endtask

  task automatic push_exp(input logic err);
    exp_q.push_back({err, m_wc, m_data});
  endtask

  task automatic drain(input string tag, input int bound);
    int waited;
    logic [48:0] e;
    waited = 0;
    while (exp_q.size() > 0) begin
      if (obs_cnt > rd_idx) begin
        e = exp_q.pop_front();
        last_rsp_cyc = obs_cyc[rd_idx%64];
        chk(tag, 64'(obs_log[rd_idx%64]), 64'(e));
        rd_idx++;
      end else if (waited >= bound) begin
        chk({tag, "_timeout"}, 64'(obs_cnt), 64'(rd_idx + 1));
        exp_q.delete();
      end else begin
        tick(1);
        waited++;
      end
    end
    tick(2);
    chk({tag, "_extra"}, 64'(obs_cnt), 64'(rd_idx));
  endtask

  initial begin
    int rt;
    int c1;
    logic [7:0]  ra;
    logic [31:0] rdv;

    // Reset with the command strobe already high.
    rst_n = 1'b0;
    cmd_tgl = 1'b1;
    tick(3);
    chk("rst_rsp_tgl", 64'(rsp_tgl), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("rst_wcount", 64'(wcount), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_req", {62'd0, mem_req, mem_we}, 64'(0));
    chk("rst_addr_wdata", {18'd0, mem_addr, mem_wdata}, 64'(0));
    chk("rst_core", 64'(core_rst_n), 64'(0));
    rst_n = 1'b1;
    tick(5);
    chk("no_cmd_after_reset", {obs_cnt, req_total}, 64'(0));

    send(OP_HOLD, '0, 32'd0);
    push_exp(1'b0);
    drain("hold1", 10);
    chk("hold1_core", 64'(core_rst_n), 64'(0));

    ack_delay = 3;
    send(OP_WRITE, 14'h0004, 32'h0050_0093);
    m_wc = 16'd1;
    push_exp(1'b0);
    drain("write1", 20);
    chk("write1_len", 64'(last_len), 64'(3));
    chk("write1_we", 64'(last_we), 64'(1));

    ack_delay = 1;
    send(OP_READ, 14'h0004, 32'd0);
    m_data = 32'h0050_0093;
    push_exp(1'b0);
    drain("read1", 20);
    chk("read1_latency", 64'(last_rsp_cyc - issue_cyc), 64'(2));
    chk("read1_we", 64'(last_we), 64'(0));

    send(OP_RUN, '0, 32'd0);
    push_exp(1'b0);
    drain("run", 10);
    chk("run_core", 64'(core_rst_n), 64'(1));

    rt = req_total;
    send(OP_WRITE, 14'h0008, 32'h1111_2222);
    push_exp(1'b1);
    drain("reject_write", 10);
    chk("reject_no_req", 64'(req_total), 64'(rt));

    send(OP_HOLD, '0, 32'd0);
    m_wc = 16'd0;
    push_exp(1'b0);
    drain("hold2", 10);
    chk("hold2_core", 64'(core_rst_n), 64'(0));

    // Stray ack while idle must not produce anything.
    ack_stray = 1'b1;
    tick(4);
    ack_stray = 1'b0;
    tick(2);
    chk("stray_ack", {31'd0, busy, obs_cnt}, {32'd0, rd_idx});

    ack_delay = 0;
    send(OP_READ, 14'h0030, 32'd0);
    m_data = 32'hDEAD_BEEF;
    push_exp(1'b1);
    drain("read_timeout", 300);
    chk("read_timeout_len", 64'(last_len), 64'(256));

    send(OP_WRITE, 14'h0031, 32'h3333_4444);
    push_exp(1'b1);
    drain("write_timeout", 300);
    chk("write_timeout_wc", 64'(wcount), 64'(0));

    // Second strobe lands while the first access is still in flight.
    ack_delay = 10;
    send(OP_WRITE, 14'h0020, 32'hCAFE_0020);
    m_wc = 16'd1;
    push_exp(1'b0);
    tick(3);
    chk("b2b_busy", 64'(busy), 64'(1));
    send(OP_READ, 14'h0020, 32'd0);
    m_data = 32'hCAFE_0020;
    push_exp(1'b0);
    drain("b2b", 60);
    c1 = obs_cyc[(rd_idx - 2) % 64];
    chk("b2b_gap", 64'(last_rsp_cyc - c1), 64'(11));

    for (int i = 0; i < 6; i++) begin
      ra  = 8'($urandom_range(64, 200));
      rdv = $urandom;
      ack_delay = $urandom_range(1, 5);
      send(OP_WRITE, {6'd0, ra}, rdv);
      m_wc = m_wc + 16'd1;
      push_exp(1'b0);
      drain("rand_write", 20);
      send(OP_READ, {6'd0, ra}, 32'd0);
      m_data = rdv;
      push_exp(1'b0);
      drain("rand_read", 20);
    end

    // Reset in the middle of a read that is never acknowledged.
    ack_delay = 0;
    send(OP_READ, 14'h0040, 32'd0);
    tick(5);
    chk("mid_req_before", 64'(mem_req), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {62'd0, mem_req, busy}, 64'(0));
    chk("mid_rst_core", 64'(core_rst_n), 64'(0));
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("mid_rst_no_rsp", 64'(obs_cnt), 64'(rd_idx));
    chk("mid_rst_state", {31'd0, core_rst_n, wcount, rsp_data[15:0]}, 64'(0));

    ack_delay = 2;
    send(OP_WRITE, 14'h0050, 32'h5555_AAAA);
    m_wc = 16'd1;
    m_data = 32'd0;
    push_exp(1'b0);
    drain("post_rst_write", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
